// File: rtl/game_sequencer.sv
// Round controller for Flappy VGA: INIT/READY/PLAY/LOSE flow, tick-derived
// scroll/flight enables, BCD score, best score, difficulty level and lose flash.
module game_sequencer #(
  parameter int TICK_DIV      = 1048576,
  parameter int SPEEDUP_EVERY = 5,
  parameter int LOSE_HOLD     = 48
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       start_btn,
  input  logic       ack_btn,
  input  logic       collide,
  input  logic       pipe_passed,
  input  logic       coin_got,
  output logic       q_Initial,
  output logic       q_Ready,
  output logic       q_Play,
  output logic       q_Lose,
  output logic       clear,
  output logic       scroll_en,
  output logic       flight_en,
  output logic [7:0] score,
  output logic [7:0] best,
  output logic [1:0] level,
  output logic       flash
);

  localparam int DIV_W  = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam int HOLD_W = (LOSE_HOLD < 1) ? 1 : $clog2(LOSE_HOLD + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LOSE_HOLD);
  localparam logic [9:0]        STEP     = 10'(SPEEDUP_EVERY);

  // valid/ready does not apply here: button inputs are levels turned into
  // one-cycle edges internally, and every event input is sampled each cycle.
  typedef enum logic [1:0] {S_INIT, S_READY, S_PLAY, S_LOSE} state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              start_prev_q, start_prev_d;
  logic              ack_prev_q, ack_prev_d;
  logic [1:0]        scroll_ph_q, scroll_ph_d;
  logic              flight_ph_q, flight_ph_d;
  logic [6:0]        pipe_cnt_q, pipe_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [2:0]        flash_cnt_q, flash_cnt_d;
  logic              flash_q, flash_d;
  logic              lose_first_q, lose_first_d;
  logic [7:0]        score_q, score_d;
  logic [7:0]        best_q, best_d;
  logic [1:0]        level_q, level_d;
  logic              scroll_en_q, scroll_en_d;
  logic              flight_en_q, flight_en_d;

  logic       tick, start_edge, ack_edge, in_play, in_lose, enter_lose;
  logic [1:0] add;
  logic [4:0] units_sum, tens_sum;
  logic [9:0] thresh;

  always_comb begin
    tick       = (div_q == DIV_LAST);
    start_edge = start_btn & ~start_prev_q;
    ack_edge   = ack_btn & ~ack_prev_q;
    in_play    = (state_q == S_PLAY);
    in_lose    = (state_q == S_LOSE);
    add        = {coin_got, 1'b0} + {1'b0, pipe_passed};
    units_sum  = {1'b0, score_q[3:0]} + {3'b000, add};
    tens_sum   = {1'b0, score_q[7:4]};
    thresh     = STEP * ({8'd0, level_q} + 10'd1);

    state_d = state_q;
    case (state_q)
      S_INIT:  state_d = S_READY;
      S_READY: if (start_edge) state_d = S_PLAY;
      S_PLAY:  if (collide) state_d = S_LOSE;
      S_LOSE:  if (ack_edge && (hold_q == HOLD_MAX)) state_d = S_INIT;
      default: state_d = S_INIT;
    endcase
    enter_lose = (state_d == S_LOSE) && !in_lose;

    div_d        = tick ? '0 : div_q + 1'b1;
    start_prev_d = start_btn;
    ack_prev_d   = ack_btn;
    scroll_ph_d  = scroll_ph_q;
    flight_ph_d  = flight_ph_q;
    pipe_cnt_d   = pipe_cnt_q;
    hold_d       = hold_q;
    flash_cnt_d  = flash_cnt_q;
    flash_d      = flash_q;
    lose_first_d = enter_lose;
    score_d      = score_q;
    best_d       = best_q;
    level_d      = level_q;
    scroll_en_d  = 1'b0;
    flight_en_d  = 1'b0;

    // A pulse earned on the collide cycle is suppressed by requiring PLAY next.
    if (in_play && tick) begin
      if (scroll_ph_q >= (2'd3 - level_q)) begin
        scroll_ph_d = 2'd0;
        scroll_en_d = (state_d == S_PLAY);
      end else begin
        scroll_ph_d = scroll_ph_q + 2'd1;
      end
      flight_ph_d = ~flight_ph_q;
      flight_en_d = flight_ph_q && (state_d == S_PLAY);
    end

    if (in_play && (add != 2'd0)) begin
      if (units_sum > 5'd9) begin
        units_sum = units_sum - 5'd10;
        tens_sum  = tens_sum + 5'd1;
      end
      score_d = (tens_sum > 5'd9) ? 8'h99 : {tens_sum[3:0], units_sum[3:0]};
    end

    if (in_play && pipe_passed && (pipe_cnt_q != 7'd127))
      pipe_cnt_d = pipe_cnt_q + 7'd1;
    if ((level_q != 2'd3) && ({3'b000, pipe_cnt_q} >= thresh))
      level_d = level_q + 2'd1;

    if (in_lose && lose_first_q && (score_q > best_q))
      best_d = score_q;

    if (enter_lose) begin
      hold_d      = '0;
      flash_cnt_d = 3'd0;
      flash_d     = 1'b1;
    end else if (in_lose && tick) begin
      if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
      flash_cnt_d = flash_cnt_q + 3'd1;
      if (flash_cnt_q == 3'd7) flash_d = ~flash_q;
    end
    if (state_d != S_LOSE) flash_d = 1'b0;

    // INIT only ever lasts one cycle, so state_d == INIT marks its entry.
    if (state_d == S_INIT) begin
      score_d     = 8'h00;
      level_d     = 2'd0;
      pipe_cnt_d  = 7'd0;
      scroll_ph_d = 2'd0;
      flight_ph_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_INIT;
      div_q        <= '0;
      start_prev_q <= 1'b1;
      ack_prev_q   <= 1'b1;
      scroll_ph_q  <= 2'd0;
      flight_ph_q  <= 1'b0;
      pipe_cnt_q   <= 7'd0;
      hold_q       <= '0;
      flash_cnt_q  <= 3'd0;
      flash_q      <= 1'b0;
      lose_first_q <= 1'b0;
      score_q      <= 8'h00;
      best_q       <= 8'h00;
      level_q      <= 2'd0;
      scroll_en_q  <= 1'b0;
      flight_en_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      start_prev_q <= start_prev_d;
      ack_prev_q   <= ack_prev_d;
      scroll_ph_q  <= scroll_ph_d;
      flight_ph_q  <= flight_ph_d;
      pipe_cnt_q   <= pipe_cnt_d;
      hold_q       <= hold_d;
      flash_cnt_q  <= flash_cnt_d;
      flash_q      <= flash_d;
      lose_first_q <= lose_first_d;
      score_q      <= score_d;
      best_q       <= best_d;
      level_q      <= level_d;
      scroll_en_q  <= scroll_en_d;
      flight_en_q  <= flight_en_d;
    end
  end

  assign q_Initial = (state_q == S_INIT);
  assign q_Ready   = (state_q == S_READY);
  assign q_Play    = (state_q == S_PLAY);
  assign q_Lose    = (state_q == S_LOSE);
  assign clear     = q_Initial;
  assign scroll_en = scroll_en_q;
  assign flight_en = flight_en_q;
  assign score     = score_q;
  assign best      = best_q;
  assign level     = level_q;
  assign flash     = flash_q;

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Central game-flow controller for the Flappy VGA design. It owns the round state machine (init, ready, play, lose) and derives the scroll and flight enable pulses from one free-running tick. It keeps the BCD score, the best score and the difficulty level, and drives the lose flash. The pipe/coin RAM, flight control and VGA colour logic are all sequenced from its outputs.

## Interface
- TICK_DIV, 1048576: Clk cycles per game tick (2^20 ≈ 48 Hz at 50 MHz); legal values ≥ 2.
- SPEEDUP_EVERY, 5: number of pipes passed per level increase.
- LOSE_HOLD, 48: minimum ticks spent in LOSE before an acknowledge is accepted.
- Clk  in  1  system clock; the only clock in the block.
- reset_n  in  1  asynchronous, active-low reset.
- start_btn  in  1  start button level, already synchronous to Clk.
- ack_btn  in  1  acknowledge button level, synchronous.
- collide  in  1  collision level from obstacle logic.
- pipe_passed  in  1  one-cycle pulse when a pipe leaves scope.
- coin_got  in  1  one-cycle pulse when a coin is collected.
- q_Initial, q_Ready, q_Play, q_Lose  out  1 each  one-hot state decode.
- clear  out  1  equals q_Initial; clears the pipe/coin RAM and flight position.
- scroll_en  out  1  one-cycle pipe-scroll enable.
- flight_en  out  1  one-cycle bird-update enable.
- score  out  8  two BCD digits, with [7:4] as the tens digit.
- best  out  8  best score, BCD.
- level  out  2  difficulty level, 0–3.
- flash  out  1  lose flash drive for the blue channel.

## Operation
- **Reset values:** state = INIT, so q_Initial = clear = 1. All other outputs are 0. The internal counters are 0. Both button-history registers reset to 1, so a button held through reset does not start or acknowledge.
- **Edge detect:** start_edge = start_btn & ~start_prev. ack_edge is formed the same way from ack_btn.
- **Tick:** a free-running divider counts 0..TICK_DIV-1. The internal `tick` is high on the cycle the divider equals TICK_DIV-1. The divider runs in every state.

**State machine**
- INIT → READY unconditionally after one cycle. On entry to INIT: score = 0, level = 0, pipe count = 0, phase counters = 0. best is retained.
- READY → PLAY on start_edge.
- PLAY → LOSE on any cycle where collide = 1.
- LOSE → INIT on ack_edge, but only once the hold count reaches LOSE_HOLD. An ack_edge before that is dropped and is not remembered.

**Enables**
- Both enables are 0 outside PLAY.
- scroll_en: a scroll phase counter advances on each tick in PLAY. scroll_en pulses on the tick where the counter reaches 3-level, after which the counter returns to 0. This gives one scroll per 4, 3, 2 or 1 ticks for levels 0 to 3.
- flight_en pulses on every second tick in PLAY, counting from the first tick after PLAY entry.

**Score**
- Events count only in PLAY.
- pipe_passed adds 1 and coin_got adds 2. When both occur in the same cycle, the score adds 3.
- Addition is BCD with a decimal carry from the units digit into the tens digit.
- The score saturates at 0x99 and never wraps.

**Level**
- A 7-bit binary pipe counter increments on pipe_passed in PLAY and saturates at 127. Coins do not advance it.
- level increments when the pipe counter reaches SPEEDUP_EVERY×(level+1). level saturates at 3.

**Collision in the same cycle as a score event**
- The score event is still applied.
- The next state is LOSE.

**Best**
- In the first LOSE cycle, best = score if score > best (unsigned compare of the packed BCD). The score is final by that cycle.

**Flash**
- flash = 0 outside LOSE.
- In LOSE, flash toggles every 8 ticks, starting at 1 on the first LOSE cycle.

**Hold counter**
- Cleared on LOSE entry.
- Increments on each tick in LOSE and saturates at LOSE_HOLD.

## Timing
- All outputs are registered except the q_* decodes and clear, which are decodes of the state register.
- scroll_en and flight_en assert in the Clk cycle after the qualifying tick. Each is exactly one cycle wide.
- Button to state change: an edge sampled at cycle n gives the new state visible at n+1.
- collide sampled at cycle n gives q_Lose = 1 at n+1. scroll_en and flight_en are 0 from n+1 onward, including any pulse already due from a tick at n.
- Score event at cycle n gives the updated score at n+1. The level update appears one cycle after the pipe counter reaches its threshold.
- reset_n asserted mid-round: all state returns to reset values immediately, including best.

## Test plan
- **Reset and start (TICK_DIV=4):** hold start_btn high through reset release, then keep it high → state stays READY after one INIT cycle. Then drop and raise start_btn → q_Play = 1 one cycle after the rise. flight_en pulses every 8 Clk and scroll_en every 16 Clk.
- **BCD carry:** in PLAY, 4× coin_got followed by 2× pipe_passed → score 0x10. One simultaneous pipe_passed + coin_got from 0x98 → score 0x99, not wrapped.
- **Level ramp (SPEEDUP_EVERY=2):** 6 pipe_passed pulses → level 3, and scroll_en fires on every tick. A 7th pulse → level stays 3.
- **Collide with pass in the same cycle (score 0x07):** → score 0x08, q_Lose = 1, best = 0x08. No further scroll_en. flash toggles every 32 Clk.
- **Acknowledge hold (LOSE_HOLD=3, TICK_DIV=4):** ack_edge after 2 ticks → stays in LOSE. ack_edge after 3 ticks → INIT for one cycle with clear = 1, then READY. score = 0, best keeps its value.
- **Reset mid-PLAY:** pulse reset_n low → all outputs return to reset values at once, with best = 0.
